// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle,
// answered on a response stream with read data or a timeout error.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic [CNT_W-1:0] stat_txn_o,
  output logic [CNT_W-1:0] stat_tmo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // TIMEOUT=0 still needs a 1-bit counter; it simply never matches.
  localparam int unsigned TMO_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             accept;
  logic             acked;
  logic             tmo_hit;
  logic             rsp_done;

  // Next-state decode; an ack on the last timeout cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    accept    = (state == S_IDLE) && cmd_valid_i;
    acked     = (state == S_BUS) && wbm_ack_i;
    tmo_hit   = (TIMEOUT != 0) && (state == S_BUS) && !wbm_ack_i &&
                (tmo_cnt == TMO_W'(TMO_LAST));
    rsp_done  = (state == S_RESP) && rsp_ready_i;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_BUS;
      S_BUS:   if (acked || tmo_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Registered outputs follow the next state so they line up with it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      stat_txn_o  <= '0;
      stat_tmo_o  <= '0;
      tmo_cnt     <= '0;
    end else begin
      cmd_ready_o <= (state_nxt == S_IDLE);
      wbm_cyc_o   <= (state_nxt == S_BUS);
      wbm_stb_o   <= (state_nxt == S_BUS);
      rsp_valid_o <= (state_nxt == S_RESP);
      if (accept) begin
        wbm_we_o  <= cmd_we_i;
        wbm_sel_o <= cmd_sel_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        tmo_cnt   <= '0;
      end
      if (acked) begin
        rsp_dat_o  <= wbm_we_o ? 32'h0 : wbm_dat_i;
        rsp_err_o  <= 1'b0;
        stat_txn_o <= stat_txn_o + CNT_W'(1);
      end else if (tmo_hit) begin
        rsp_dat_o  <= 32'h0;
        rsp_err_o  <= 1'b1;
        stat_tmo_o <= stat_tmo_o + CNT_W'(1);
      end else if (state == S_BUS) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT=8 and a scripted responder.
module tb_wb_cmd_master;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [3:0]       cmd_sel;
  logic [31:0]      cmd_adr;
  logic [31:0]      cmd_dat;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_dat;
  logic             rsp_err;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [3:0]       sel;
  logic [31:0]      adr;
  logic [31:0]      wdat;
  logic             ack;
  logic [31:0]      rdat;
  logic [CNT_W-1:0] stat_txn;
  logic [CNT_W-1:0] stat_tmo;

  int n_chk = 0;
  int n_bad = 0;
  int cyc_n;
  int lat;
  int stb_err;
  logic [31:0] snap_adr;
  logic [31:0] snap_dat;
  logic [3:0]  snap_sel;
  logic        snap_we;
  logic [31:0] hold_dat;

  wb_cmd_master #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
    .stat_txn_o(stat_txn), .stat_tmo_o(stat_tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; ack on bus cycle ack_at (0 = never). Returns with rsp pending.
  task automatic do_txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rd);
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    tick();
    cmd_valid = 1'b0;
    snap_adr = adr; snap_dat = wdat; snap_sel = sel; snap_we = we;
    lat = 1; cyc_n = 0; stb_err = 0;
    for (int i = 0; i < 300; i++) begin
      if (stb !== cyc) stb_err++;
      if (cyc) cyc_n++;
      if (rsp_valid) break;
      ack  = (cyc_n == ack_at);
      rdat = ack ? rd : 32'hBAD0_BAD0;
      tick();
      ack = 1'b0;
      lat++;
    end
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_adr = 32'h0; cmd_dat = 32'h0; rsp_ready = 1'b0; ack = 1'b0; rdat = 32'h0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_txn", 32'(stat_txn), 32'd0);

    // write, zero wait states
    do_txn(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1, 32'h5555_5555);
    chk("w_adr", snap_adr, 32'h3000_0004);
    chk("w_dat", snap_dat, 32'hDEAD_BEEF);
    chk("w_sel", 32'(snap_sel), 32'hF);
    chk("w_we", 32'(snap_we), 32'd1);
    chk("w_cyc_n", 32'(cyc_n), 32'd1);
    chk("w_lat", 32'(lat), 32'd2);
    chk("w_stb", 32'(stb_err), 32'd0);
    chk("w_rsp_dat", rsp_dat, 32'h0);
    chk("w_rsp_err", 32'(rsp_err), 32'd0);
    chk("w_txn", 32'(stat_txn), 32'd1);
    chk("w_ready_busy", 32'(cmd_ready), 32'd0);
    take_rsp();
    chk("idle_adr_kept", adr, 32'h3000_0004);

    // read, 3 wait states
    do_txn(1'b0, 4'h3, 32'h0000_0100, 32'hFFFF_FFFF, 4, 32'h1234_5678);
    chk("r_cyc_n", 32'(cyc_n), 32'd4);
    chk("r_lat", 32'(lat), 32'd5);
    chk("r_we", 32'(snap_we), 32'd0);
    chk("r_rsp_dat", rsp_dat, 32'h1234_5678);
    chk("r_rsp_err", 32'(rsp_err), 32'd0);
    chk("r_txn", 32'(stat_txn), 32'd2);
    take_rsp();

    // timeout, no ack
    do_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 0, 32'h0);
    chk("t_cyc_n", 32'(cyc_n), 32'd8);
    chk("t_cyc_low", 32'(cyc), 32'd0);
    chk("t_rsp_err", 32'(rsp_err), 32'd1);
    chk("t_rsp_dat", rsp_dat, 32'h0);
    chk("t_tmo", 32'(stat_tmo), 32'd1);
    chk("t_txn", 32'(stat_txn), 32'd2);
    take_rsp();

    // ack on the final timeout cycle
    do_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 8, 32'hCAFE_F00D);
    chk("l_cyc_n", 32'(cyc_n), 32'd8);
    chk("l_rsp_err", 32'(rsp_err), 32'd0);
    chk("l_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    chk("l_txn", 32'(stat_txn), 32'd3);
    chk("l_tmo", 32'(stat_tmo), 32'd1);
    take_rsp();

    // back-pressure with a second command waiting
    do_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 2, 32'hA5A5_0001);
    hold_dat = rsp_dat;
    chk("bp_first_dat", hold_dat, 32'hA5A5_0001);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'h1; cmd_adr = 32'h0000_0500;
    cmd_dat = 32'h0000_00EE;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_dat", rsp_dat, hold_dat);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_cyc", 32'(cyc), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bb_rsp_gone", 32'(rsp_valid), 32'd0);
    chk("bb_ready", 32'(cmd_ready), 32'd1);
    chk("bb_not_yet", 32'(cyc), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bb_cyc", 32'(cyc), 32'd1);
    chk("bb_adr", adr, 32'h0000_0500);
    chk("bb_ready_busy", 32'(cmd_ready), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bb_rsp", 32'(rsp_valid), 32'd1);
    chk("bb_txn", 32'(stat_txn), 32'd5);
    take_rsp();

    // reset during BUS after 2 wait states, then a late ack
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0600;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("rs_cyc_before", 32'(cyc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_cyc", 32'(cyc), 32'd0);
    chk("rs_stb", 32'(stb), 32'd0);
    chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rs_ready", 32'(cmd_ready), 32'd1);
    chk("rs_txn", 32'(stat_txn), 32'd0);
    chk("rs_tmo", 32'(stat_tmo), 32'd0);
    chk("rs_adr", adr, 32'h0);
    ack = 1'b1; rdat = 32'h7777_7777;
    tick();
    ack = 1'b0;
    chk("late_ack_rsp", 32'(rsp_valid), 32'd0);
    chk("late_ack_txn", 32'(stat_txn), 32'd0);
    chk("late_ack_dat", rsp_dat, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
